// File: rtl/spi_cap_pkg.sv
// Shared types and sizing helpers for the SOUT readback capture block.
package spi_cap_pkg;

  localparam int WORD_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  function automatic int cnt_w(input int word_w, input int frame_words);
    return $clog2(word_w * frame_words + 1);
  endfunction

endpackage

// File: rtl/spi_sout_capture_if.sv
// Valid/ready read port carrying captured words and their frame tag.
interface spi_sout_capture_if #(
  parameter int WORD_W = 32
) ();

  logic [WORD_W-1:0] rd_data;
  logic              rd_tag;
  logic              rd_valid;
  logic              rd_ready;

  modport master (
    output rd_data,
    output rd_tag,
    output rd_valid,
    input  rd_ready
  );

  modport slave (
    input  rd_data,
    input  rd_tag,
    input  rd_valid,
    output rd_ready
  );

endinterface

// File: rtl/spi_cap_fifo.sv
// First-word-fall-through FIFO with wrap-bit pointers; a push into a full
// FIFO only lands when a pop frees a slot in the same cycle.
module spi_cap_fifo #(
  parameter int W     = 33,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop_req,
  output logic [W-1:0] dout,
  output logic         valid,
  output logic         drop
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  wr_q, wr_d;
  logic [AW:0]  rd_q, rd_d;
  logic [W-1:0] mem_q [DEPTH];
  logic         empty;
  logic         full;
  logic         pop;
  logic         wr_en;

  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[AW-1:0] == rd_q[AW-1:0])
              && (wr_q[AW] != rd_q[AW]);
  assign pop   = pop_req && !empty;
  assign wr_en = push && (!full || pop);
  assign drop  = push && full && !pop;

  always_comb begin
    wr_d = wr_q + {{AW{1'b0}}, wr_en};
    rd_d = rd_q + {{AW{1'b0}}, pop};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_q[AW-1:0]] <= din;
  end

  // Gate the head so an empty FIFO always presents zeros.
  assign dout  = empty ? '0 : mem_q[rd_q[AW-1:0]];
  assign valid = !empty;

endmodule

// File: rtl/spi_sout_capture.sv
// Deserialises the SPI array SOUT stream into tagged words and buffers
// them for host readback.
module spi_sout_capture
  import spi_cap_pkg::*;
#(
  parameter int WORD_W      = WORD_W_DEF,
  parameter int FRAME_WORDS = 4,
  parameter int FIFO_DEPTH  = 4,
  localparam int CW = cnt_w(WORD_W, FRAME_WORDS)
) (
  input  logic                   SCLK,
  input  logic                   RST,
  input  logic                   start,
  input  logic                   shift_en,
  input  logic                   SOUT,
  input  logic                   REGSEL,
  spi_sout_capture_if.master     rd,
  output logic                   busy,
  output logic                   done,
  output logic                   overflow,
  output logic [CW-1:0]          bit_cnt
);

  localparam int TOTAL = WORD_W * FRAME_WORDS;
  localparam int LW    = $clog2(WORD_W);

  state_t            state_q, state_d;
  logic [CW-1:0]     bit_cnt_q, bit_cnt_d;
  logic [WORD_W-2:0] sr_q, sr_d;
  logic              tag_q, tag_d;
  logic              ovf_q, ovf_d;

  logic              start_ok;
  logic              shift_ok;
  logic [CW-1:0]     cnt_inc;
  logic              word_done;
  logic              last_bit;
  logic [WORD_W-1:0] push_word;
  logic              drop;

  assign start_ok  = start && (state_q == IDLE);
  assign shift_ok  = shift_en && (state_q == SHIFT);
  assign cnt_inc   = bit_cnt_q + CW'(1);
  assign word_done = shift_ok && (cnt_inc[LW-1:0] == '0);
  assign last_bit  = shift_ok && (cnt_inc == CW'(TOTAL));
  assign push_word = {sr_q, SOUT};

  always_ff @(posedge SCLK or posedge RST) begin
    if (RST) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start_ok) state_d = SHIFT;
      SHIFT:   if (last_bit) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q != IDLE);
    done = (state_q == DONE);
  end

  always_comb begin
    bit_cnt_d = bit_cnt_q;
    sr_d      = sr_q;
    tag_d     = tag_q;
    ovf_d     = ovf_q;
    if (start_ok) begin
      tag_d     = REGSEL;
      bit_cnt_d = '0;
      sr_d      = '0;
      ovf_d     = 1'b0;
    end else begin
      if (shift_ok) begin
        sr_d      = push_word[WORD_W-2:0];
        bit_cnt_d = cnt_inc;
      end
      if (drop) ovf_d = 1'b1;
    end
  end

  always_ff @(posedge SCLK or posedge RST) begin
    if (RST) begin
      bit_cnt_q <= '0;
      sr_q      <= '0;
      tag_q     <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      bit_cnt_q <= bit_cnt_d;
      sr_q      <= sr_d;
      tag_q     <= tag_d;
      ovf_q     <= ovf_d;
    end
  end

  assign bit_cnt  = bit_cnt_q;
  assign overflow = ovf_q;

  spi_cap_fifo #(
    .W     (WORD_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (SCLK),
    .rst     (RST),
    .push    (word_done),
    .din     ({tag_q, push_word}),
    .pop_req (rd.rd_ready),
    .dout    ({rd.rd_tag, rd.rd_data}),
    .valid   (rd.rd_valid),
    .drop    (drop)
  );

endmodule

// File: tb/tb_spi_sout_capture.sv
// Scoreboard bench: stimulus queues expected {tag,word}; a monitor pops on
// each read handshake and compares.
module tb_spi_sout_capture;

  logic       SCLK = 1'b0;
  logic       RST = 1'b1;
  logic       start = 1'b0;
  logic       shift_en = 1'b0;
  logic       SOUT = 1'b0;
  logic       REGSEL = 1'b0;
  logic       busy;
  logic       done;
  logic       overflow;
  logic [7:0] bit_cnt;

  spi_sout_capture_if #(.WORD_W(32)) rif ();

  spi_sout_capture #(
    .WORD_W      (32),
    .FRAME_WORDS (4),
    .FIFO_DEPTH  (4)
  ) dut (
    .SCLK     (SCLK),
    .RST      (RST),
    .start    (start),
    .shift_en (shift_en),
    .SOUT     (SOUT),
    .REGSEL   (REGSEL),
    .rd       (rif),
    .busy     (busy),
    .done     (done),
    .overflow (overflow),
    .bit_cnt  (bit_cnt)
  );

  always #5 SCLK = ~SCLK;

  int checks = 0;
  int failures = 0;
  int done_cnt = 0;
  logic [63:0] exp_q [$];
  logic [31:0] fw [4];

  task automatic check(input string nm, input logic [63:0] act,
                       input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  always @(negedge SCLK) begin
    if (!RST && done) done_cnt++;
    if (!RST && rif.rd_valid && rif.rd_ready) begin
      if (exp_q.size() == 0) begin
        check("rd_unexpected", {31'd0, rif.rd_tag, rif.rd_data}, 64'd0);
      end else begin
        check("rd_word", {31'd0, rif.rd_tag, rif.rd_data},
              exp_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge SCLK);
    #1;
  endtask

  task automatic do_start(input logic rs);
    start  = 1'b1;
    REGSEL = rs;
    tick();
    start  = 1'b0;
    REGSEL = ~rs;
  endtask

  task automatic shift_bit(input logic b);
    SOUT     = b;
    shift_en = 1'b1;
    tick();
    shift_en = 1'b0;
  endtask

  task automatic expect_frame(input logic tg);
    for (int k = 0; k < 4; k++) exp_q.push_back({31'd0, tg, fw[k]});
  endtask

  // Sends words fw[first..3]; checks done lands right after the last strobe.
  task automatic send_words(input int first, input int gap);
    for (int k = first; k < 4; k++)
      for (int i = 31; i >= 0; i--) begin
        shift_bit(fw[k][i]);
        if (!(k == 3 && i == 0)) repeat (gap) tick();
      end
    check("done_after_last", {63'd0, done}, 64'd1);
    check("bit_cnt_end", {56'd0, bit_cnt}, 64'd128);
    tick();
    check("done_width", {63'd0, done}, 64'd0);
    check("busy_fall", {63'd0, busy}, 64'd0);
  endtask

  task automatic set_basic();
    fw[0] = 32'hDEADBEEF; fw[1] = 32'h12345678;
    fw[2] = 32'h00000000; fw[3] = 32'hFFFFFFFF;
  endtask

  task automatic check_reset_vals(input string nm);
    check({nm, "_rd"}, {30'd0, rif.rd_tag, rif.rd_valid, rif.rd_data},
          64'd0);
    check({nm, "_flags"}, {53'd0, busy, done, overflow, bit_cnt}, 64'd0);
  endtask

  initial begin
    rif.rd_ready = 1'b0;
    #12;
    check_reset_vals("reset");
    RST = 1'b0;
    tick();

    // Basic frame
    set_basic();
    rif.rd_ready = 1'b1;
    expect_frame(1'b1);
    check("busy_pre", {63'd0, busy}, 64'd0);
    done_cnt = 0;
    do_start(1'b1);
    check("busy_rise", {63'd0, busy}, 64'd1);
    send_words(0, 0);
    repeat (3) tick();
    check("basic_done_cnt", 64'(done_cnt), 64'd1);
    check("basic_ovf", {63'd0, overflow}, 64'd0);
    check("basic_drained", 64'(exp_q.size()), 64'd0);

    // Overflow: fill with frame A, frame B entirely dropped
    rif.rd_ready = 1'b0;
    fw[0] = 32'h11111111; fw[1] = 32'h22222222;
    fw[2] = 32'h33333333; fw[3] = 32'h44444444;
    expect_frame(1'b0);
    do_start(1'b0);
    send_words(0, 0);
    check("full_no_ovf", {63'd0, overflow}, 64'd0);
    fw[0] = 32'hA5A5A5A5; fw[1] = 32'h5A5A5A5A;
    fw[2] = 32'hCAFEF00D; fw[3] = 32'h0BADC0DE;
    do_start(1'b1);
    send_words(0, 0);
    check("ovf_set", {63'd0, overflow}, 64'd1);
    check("hold_head", {31'd0, rif.rd_tag, rif.rd_data},
          {31'd0, 1'b0, 32'h11111111});
    rif.rd_ready = 1'b1;
    repeat (6) tick();
    check("ovf_drain_empty", {63'd0, rif.rd_valid}, 64'd0);
    check("ovf_sb_empty", 64'(exp_q.size()), 64'd0);
    check("ovf_sticky", {63'd0, overflow}, 64'd1);

    // Push+pop on full
    rif.rd_ready = 1'b0;
    fw[0] = 32'h01020304; fw[1] = 32'h05060708;
    fw[2] = 32'h090A0B0C; fw[3] = 32'h0D0E0F10;
    expect_frame(1'b0);
    do_start(1'b0);
    check("ovf_clr_start", {63'd0, overflow}, 64'd0);
    send_words(0, 0);
    fw[0] = 32'h80000001; fw[1] = 32'h7FFFFFFE;
    fw[2] = 32'h13579BDF; fw[3] = 32'h2468ACE0;
    expect_frame(1'b1);
    do_start(1'b1);
    for (int i = 31; i >= 1; i--) shift_bit(fw[0][i]);
    rif.rd_ready = 1'b1;
    shift_bit(fw[0][0]);
    check("pushpop_no_ovf", {63'd0, overflow}, 64'd0);
    send_words(1, 0);
    repeat (6) tick();
    check("pushpop_ovf_end", {63'd0, overflow}, 64'd0);
    check("pushpop_sb_empty", 64'(exp_q.size()), 64'd0);

    // Gapped strobe, every 3rd cycle
    set_basic();
    expect_frame(1'b0);
    do_start(1'b0);
    send_words(0, 2);
    repeat (3) tick();
    check("gap_sb_empty", 64'(exp_q.size()), 64'd0);

    // Start while busy
    fw[0] = 32'hFEEDFACE; fw[1] = 32'hBEEFCAFE;
    fw[2] = 32'h0000FFFF; fw[3] = 32'hFFFF0000;
    expect_frame(1'b1);
    do_start(1'b1);
    for (int k = 0; k < 2; k++)
      for (int i = 31; i >= 0; i--) shift_bit(fw[k][i]);
    do_start(1'b0);
    check("sb_cnt_kept", {56'd0, bit_cnt}, 64'd64);
    check("sb_busy", {63'd0, busy}, 64'd1);
    send_words(2, 0);
    repeat (3) tick();
    check("sb_sb_empty", 64'(exp_q.size()), 64'd0);

    // Reset mid-frame with one word buffered
    rif.rd_ready = 1'b0;
    do_start(1'b0);
    for (int i = 0; i < 40; i++) shift_bit(i[0]);
    check("pre_rst_valid", {63'd0, rif.rd_valid}, 64'd1);
    check("pre_rst_cnt", {56'd0, bit_cnt}, 64'd40);
    RST = 1'b1;
    #2;
    check_reset_vals("midrst");
    tick();
    RST = 1'b0;
    tick();
    check_reset_vals("post_rst");

    // Fresh frame after reset
    set_basic();
    rif.rd_ready = 1'b1;
    expect_frame(1'b1);
    do_start(1'b1);
    send_words(0, 0);
    repeat (3) tick();
    check("rst_frame_sb_empty", 64'(exp_q.size()), 64'd0);
    check("rst_frame_ovf", {63'd0, overflow}, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spi_sout_capture.md
# spi_sout_capture

Readback deserializer sitting directly downstream of the SPI slave array: it samples the serial `SOUT` stream, one bit per shift strobe, and packs it into 32-bit words. Words are buffered in a small FIFO with a valid/ready read port, so host-side logic can verify register contents after a configuration pass. Each frame is tagged with the `REGSEL` value latched at frame start.

## Interface
Parameters:
- `WORD_W`, 32: bits per captured word.
- `FRAME_WORDS`, 4: words per capture frame.
- `FIFO_DEPTH`, 4: word buffer depth; must be a power of two, ≥2.

Ports:
- `SCLK`, in, 1: single system clock; all logic is on its rising edge.
- `RST`, in, 1: asynchronous, active-high reset.
- `start`, in, 1: one-cycle pulse that begins a frame. Ignored while `busy`.
- `shift_en`, in, 1: sample strobe. `SOUT` is captured on each cycle where this is high while in SHIFT.
- `SOUT`, in, 1: serial readback data from the SPI array, MSB first.
- `REGSEL`, in, 1: register-chain select. Latched on `start`.
- `rd_data`, out, `WORD_W`: head-of-FIFO word.
- `rd_tag`, out, 1: `REGSEL` value latched for the frame that produced `rd_data`.
- `rd_valid`, out, 1: FIFO not empty.
- `rd_ready`, in, 1: consumer accept. A pop occurs when `rd_valid && rd_ready`.
- `busy`, out, 1: high in SHIFT and DONE.
- `done`, out, 1: one-cycle pulse at frame end.
- `overflow`, out, 1: sticky flag. Set when a word is dropped; cleared on `start` or `RST`.
- `bit_cnt`, out, clog2(`WORD_W*FRAME_WORDS`+1): bits captured in the current frame.

## Operation
- States and transitions:
  - IDLE → SHIFT on `start`.
  - SHIFT → DONE when the `WORD_W*FRAME_WORDS`-th bit is sampled.
  - DONE → IDLE unconditionally after one cycle.
- On `start`:
  - latch `REGSEL` into the frame tag;
  - clear `bit_cnt`, the shift register and `overflow`.
  - The FIFO is not cleared.
- Each accepted `shift_en` in SHIFT:
  - shift register becomes {sr[WORD_W-2:0], `SOUT`};
  - `bit_cnt` increments.
- `shift_en` outside SHIFT is ignored. So is `shift_en` in the same cycle as `start`.
- Word completion happens when the low clog2(`WORD_W`) bits of the post-increment count are zero. On completion, the word {sr[WORD_W-2:0], `SOUT`} is pushed together with the frame tag.
- Pushing to a full FIFO:
  - If a pop occurs in the same cycle, the push succeeds (simultaneous push and pop on full is legal).
  - Otherwise the word is dropped and `overflow` is set.
- Simultaneous push and pop on empty: the pop is not possible, because `rd_valid` is low that cycle; the push succeeds.
- FIFO is first-word-fall-through. Its pointers carry an extra wrap bit: full when the indices match and the wrap bits differ, empty when both match.
- `RST` mid-frame:
  - return to IDLE;
  - flush the FIFO;
  - clear all counters and flags.
  - Partial words are discarded.

## Timing
- Reset values: `rd_data`=0, `rd_tag`=0, `rd_valid`=0, `busy`=0, `done`=0, `overflow`=0, `bit_cnt`=0.
- `busy` rises the cycle after `start`.
- A completed word appears with `rd_valid` high one cycle after the completing `shift_en` (FIFO previously empty).
- `done` is asserted for exactly one cycle, the cycle after the last bit is sampled (DONE state). `busy` falls the following cycle.
- Minimum frame time is `WORD_W*FRAME_WORDS`+2 cycles with `shift_en` tied high.
- `rd_data` and `rd_tag` hold stable while `rd_valid && !rd_ready`.

## Structure
- Package `spi_cap_pkg` holds:
  - the state enum (IDLE, SHIFT, DONE);
  - the default `WORD_W`;
  - the `bit_cnt` width function.
- Sub-module `spi_cap_fifo` is a parameterised FWFT FIFO of width `WORD_W`+1 (data plus tag). It carries the full/empty logic and the push/pop-on-full rule.
- Top level holds the FSM, shift register, counters and overflow flag.

## Test plan
- **Basic frame:** `REGSEL`=1, `start`, then 128 `shift_en` cycles driving 0xDEADBEEF, 0x12345678, 0x00000000, 0xFFFFFFFF MSB first, `rd_ready`=1 → four words in order, `rd_tag`=1 on each, `done` pulses once, `overflow`=0.
- **Overflow:** `rd_ready`=0, `FIFO_DEPTH`=4, `FRAME_WORDS`=5 → 4 words retained, `overflow`=1 after the 5th word, and the 5th word is absent on drain.
- **Push+pop on full:** FIFO full, with `rd_ready`=1 in the same cycle the next word completes → no drop, `overflow` stays 0.
- **Gapped strobe:** `shift_en` asserted every 3rd cycle → identical words to the basic frame; `bit_cnt` reaches 128; `done` occurs one cycle after the last strobe.
- **Start while busy:** `start` pulse mid-frame with `REGSEL` toggled → ignored; tag and `bit_cnt` are unaffected.
- **Reset mid-frame:** `RST` pulse after 40 bits with 1 word buffered → all outputs at reset values, `rd_valid`=0; a new frame then captures correctly.
